// File: rtl/if_pkg.sv
// ============================================================================
// Package : if_pkg
// Brief   : Shared constants, FSM state encoding and bundle field slices.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

package if_pkg;

    localparam logic [31:0] c_reset_pc   = 32'h0000_0000;
    localparam logic [31:0] c_pc_inc     = 32'd4;

    // Bundle layout: nextPC occupies the upper word, instruction the lower.
    localparam int          c_nextpc_msb = 63;
    localparam int          c_nextpc_lsb = 32;
    localparam int          c_instr_msb  = 31;
    localparam int          c_instr_lsb  = 0;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_HOLD = 2'd3
    } fetch_state_t;

endpackage

`default_nettype wire

// File: rtl/fetch_pc_reg.sv
// ============================================================================
// Module : fetch_pc_reg
// Brief  : Program counter with load / increment / hold, async active-low reset.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_pc_reg
    import if_pkg::*;
#(
    parameter logic [31:0] RESET_PC = c_reset_pc
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [31:0] load_pc,
    input  logic        inc,
    output logic [31:0] pc
);

    // Load wins over increment so a redirect always replaces the stream.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc <= RESET_PC;
        end else if (load) begin
            pc <= load_pc;
        end else if (inc) begin
            pc <= pc + c_pc_inc;
        end
    end

endmodule

`default_nettype wire

// File: rtl/if_fetch_stage.sv
// ============================================================================
// Module : if_fetch_stage
// Brief  : Instruction fetch producing the {nextPC, instruction} IF/ID bundle.
//          Optional IF_PERF_CNT_EN adds saturating fetch/stall counters.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module if_fetch_stage
    import if_pkg::*;
#(
    parameter logic [31:0] RESET_PC = c_reset_pc,
    parameter int          WIDTH    = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             redirect,
    input  logic [31:0]      redirect_pc,
    output logic             imem_req,
    output logic [31:0]      imem_addr,
    input  logic             imem_gnt,
    input  logic             imem_rvalid,
    input  logic [31:0]      imem_rdata,
    output logic [WIDTH-1:0] out_bundle,
    output logic             out_valid,
    output logic             ifid_flush
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0]      perf_fetch_cnt,
    output logic [31:0]      perf_stall_cnt
`endif
);

    fetch_state_t     r_state;
    logic             r_drop;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_bundle;
    logic [31:0]      w_pc;
    logic             w_consume;

    // A bundle is consumed only when decode accepts it and no redirect kills it.
    assign w_consume = (r_state == S_HOLD) && !stall && !redirect;

    fetch_pc_reg #(
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk     (clk),
        .reset   (reset),
        .load    (redirect),
        .load_pc (redirect_pc),
        .inc     (w_consume),
        .pc      (w_pc)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_drop      <= 1'b0;
            r_out_valid <= 1'b0;
            r_bundle    <= '0;
        end else begin
            case (r_state)
                S_IDLE: r_state <= S_REQ;
                S_REQ: begin
                    if (imem_gnt) begin
                        r_state <= S_WAIT;
                        r_drop  <= redirect;
                    end
                end
                S_WAIT: begin
                    if (imem_rvalid) begin
                        r_drop <= 1'b0;
                        if (redirect || r_drop) begin
                            r_state <= S_REQ;
                        end else begin
                            r_bundle[c_nextpc_msb:c_nextpc_lsb] <= w_pc + c_pc_inc;
                            r_bundle[c_instr_msb:c_instr_lsb]   <= imem_rdata;
                            r_out_valid <= 1'b1;
                            r_state     <= S_HOLD;
                        end
                    end else if (redirect) begin
                        // The in-flight word belongs to the old stream.
                        r_drop <= 1'b1;
                    end
                end
                S_HOLD: begin
                    if (redirect || !stall) begin
                        r_out_valid <= 1'b0;
                        r_state     <= S_REQ;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign imem_req   = (r_state == S_REQ);
    assign imem_addr  = w_pc;
    assign out_bundle = r_bundle;
    assign out_valid  = r_out_valid;
    assign ifid_flush = ~r_out_valid | redirect;

`ifdef IF_PERF_CNT_EN
    logic [31:0] r_fetch_cnt;
    logic [31:0] r_stall_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_fetch_cnt <= '0;
            r_stall_cnt <= '0;
        end else begin
            if (w_consume && (r_fetch_cnt != 32'hFFFF_FFFF)) begin
                r_fetch_cnt <= r_fetch_cnt + 32'd1;
            end
            if ((r_state == S_HOLD) && stall && (r_stall_cnt != 32'hFFFF_FFFF)) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
        end
    end

    assign perf_fetch_cnt = r_fetch_cnt;
    assign perf_stall_cnt = r_stall_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_if_fetch_stage.sv
// ============================================================================
// Module : tb_if_fetch_stage
// Brief  : Directed scoreboard bench for if_fetch_stage (two RESET_PC values).
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_if_fetch_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;

    logic        req_a, req_b;
    logic [31:0] addr_a, addr_b;
    logic [63:0] bundle_a, bundle_b;
    logic        valid_a, valid_b;
    logic        flush_a, flush_b;
`ifdef IF_PERF_CNT_EN
    logic [31:0] pfc_a, psc_a, pfc_b, psc_b;
`endif

    int checks   = 0;
    int failures = 0;
    logic [63:0] q_a[$];
    logic [63:0] q_b[$];
    logic [63:0] held_a;

    always #5 clk = ~clk;

    if_fetch_stage #(.RESET_PC(32'h0000_0000), .WIDTH(64)) dut_a (
        .clk(clk), .reset(reset), .stall(stall), .redirect(redirect),
        .redirect_pc(redirect_pc), .imem_req(req_a), .imem_addr(addr_a),
        .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .out_bundle(bundle_a), .out_valid(valid_a), .ifid_flush(flush_a)
`ifdef IF_PERF_CNT_EN
        , .perf_fetch_cnt(pfc_a), .perf_stall_cnt(psc_a)
`endif
    );

    if_fetch_stage #(.RESET_PC(32'hFFFF_FFFC), .WIDTH(64)) dut_b (
        .clk(clk), .reset(reset), .stall(stall), .redirect(redirect),
        .redirect_pc(redirect_pc), .imem_req(req_b), .imem_addr(addr_b),
        .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .out_bundle(bundle_b), .out_valid(valid_b), .ifid_flush(flush_b)
`ifdef IF_PERF_CNT_EN
        , .perf_fetch_cnt(pfc_b), .perf_stall_cnt(psc_b)
`endif
    );

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic pop_a(input string tag);
        if (q_a.size() == 0) begin
            checks++;
            failures++;
            $error("FAIL %s observed=empty_queue expected=entry", tag);
        end else begin
            held_a = q_a.pop_front();
            chk(tag, bundle_a, held_a);
        end
    endtask

    task automatic pop_b(input string tag);
        logic [63:0] e;
        if (q_b.size() == 0) begin
            checks++;
            failures++;
            $error("FAIL %s observed=empty_queue expected=entry", tag);
        end else begin
            e = q_b.pop_front();
            chk(tag, bundle_b, e);
        end
    endtask

    initial begin
        reset = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
        imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
        step(); step();
        chk("rst_req",    {63'd0, req_a},   64'd0);
        chk("rst_addr",   {32'd0, addr_a},  64'd0);
        chk("rst_addr_b", {32'd0, addr_b},  64'h0000_0000_FFFF_FFFC);
        chk("rst_valid",  {63'd0, valid_a}, 64'd0);
        chk("rst_bundle", bundle_a,         64'd0);
        chk("rst_flush",  {63'd0, flush_a}, 64'd1);

        // Test 1/5: release reset, gnt tied high, rvalid one cycle after gnt.
        reset = 1'b1; imem_gnt = 1'b1;
        step();
        chk("t1_req",    {63'd0, req_a},  64'd1);
        chk("t1_addr",   {32'd0, addr_a}, 64'd0);
        chk("t5_addr_b", {32'd0, addr_b}, 64'h0000_0000_FFFF_FFFC);
        step();
        imem_rvalid = 1'b1; imem_rdata = 32'h2001_0005;
        q_a.push_back({32'h0000_0004, 32'h2001_0005});
        q_b.push_back({32'h0000_0000, 32'h2001_0005});
        chk("t1_req_wait", {63'd0, req_a}, 64'd0);
        step();
        imem_rvalid = 1'b0; stall = 1'b1;
        chk("t1_valid", {63'd0, valid_a}, 64'd1);
        pop_a("t1_bundle");
        pop_b("t5_bundle_b");
        chk("t1_flush", {63'd0, flush_a}, 64'd0);

        // Test 2: hold under stall for five cycles.
        for (int i = 0; i < 5; i++) begin
            step();
            chk("t2_bundle", bundle_a,         held_a);
            chk("t2_req",    {63'd0, req_a},   64'd0);
            chk("t2_flush",  {63'd0, flush_a}, 64'd0);
        end
        stall = 1'b0;
        step();
        chk("t2_req_next",  {63'd0, req_a},  64'd1);
        chk("t2_addr_next", {32'd0, addr_a}, 64'd4);
        chk("t5_addr_b2",   {32'd0, addr_b}, 64'd0);
        chk("t2_valid",     {63'd0, valid_a}, 64'd0);
        step();

        // Test 3: redirect while waiting; the late word is dropped.
        redirect = 1'b1; redirect_pc = 32'h0000_0100;
        #1;
        chk("t3_flush_redir", {63'd0, flush_a}, 64'd1);
        step();
        redirect = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        step();
        imem_rvalid = 1'b0;
        chk("t3_valid",    {63'd0, valid_a}, 64'd0);
        chk("t3_req",      {63'd0, req_a},   64'd1);
        chk("t3_addr",     {32'd0, addr_a},  64'h100);
        step();
        imem_rvalid = 1'b1; imem_rdata = 32'h1111_2222;
        q_a.push_back({32'h0000_0104, 32'h1111_2222});
        step();
        imem_rvalid = 1'b0;
        chk("t3_valid2", {63'd0, valid_a}, 64'd1);
        pop_a("t3_bundle");

        // Test 4: redirect and stall together while holding.
        stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h0000_0200;
        #1;
        chk("t4_flush_now", {63'd0, flush_a}, 64'd1);
        step();
        stall = 1'b0; redirect = 1'b0;
        chk("t4_valid", {63'd0, valid_a}, 64'd0);
        chk("t4_req",   {63'd0, req_a},   64'd1);
        chk("t4_addr",  {32'd0, addr_a},  64'h200);
`ifdef IF_PERF_CNT_EN
        chk("perf_fetch", {32'd0, pfc_a}, 64'd1);
        chk("perf_stall", {32'd0, psc_a}, 64'd6);
`endif
        step();

        // Test 6: asynchronous reset while waiting.
        reset = 1'b0;
        #1;
        chk("t6_req",   {63'd0, req_a},   64'd0);
        chk("t6_valid", {63'd0, valid_a}, 64'd0);
        chk("t6_addr",  {32'd0, addr_a},  64'd0);
`ifdef IF_PERF_CNT_EN
        chk("t6_perf_fetch", {32'd0, pfc_a}, 64'd0);
        chk("t6_perf_stall", {32'd0, psc_a}, 64'd0);
`endif
        imem_gnt = 1'b0;
        step(); step();
        reset = 1'b1;
        step();
        chk("t6_req_rel",  {63'd0, req_a},  64'd1);
        chk("t6_addr_rel", {32'd0, addr_a}, 64'd0);
        step();
        chk("t6_req_nognt",  {63'd0, req_a},  64'd1);
        chk("t6_addr_nognt", {32'd0, addr_a}, 64'd0);
        chk("sb_empty", {32'd0, 32'(q_a.size())}, 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
